// File: rtl/audio_clip_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_clip_mixer_pkg
// Purpose  : Shared types, constants and sample helpers for the clip mixer.
// Revision : 1.0 - initial release
// ============================================================================
package audio_clip_mixer_pkg;

  // Frame sequencer states: wait for divider, then ISSUE/CAPTURE per channel,
  // then one OUTPUT cycle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  localparam logic [7:0] SILENCE    = 8'h80;
  localparam int         SAMPLE_MIN = -128;
  localparam int         SAMPLE_MAX = 127;

  // Offset-binary ROM byte to two's complement: subtracting 128 is a flip of the MSB.
  function automatic logic signed [7:0] to_signed_sample(input logic [7:0] raw);
    return {~raw[7], raw[6:0]};
  endfunction

  // Clamp a wide signed mix into the 8-bit signed sample range.
  function automatic logic signed [7:0] saturate(input logic signed [31:0] value);
    logic signed [7:0] result;
    if (value > SAMPLE_MAX) begin
      result = 8'sh7f;
    end else if (value < SAMPLE_MIN) begin
      result = 8'sh80;
    end else begin
      result = value[7:0];
    end
    return result;
  endfunction

  // Two's complement back to offset-binary (adds 128 modulo 256).
  function automatic logic [7:0] to_offset_binary(input logic signed [7:0] s);
    return {~s[7], s[6:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_clip_mixer_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_clip_mixer_if
// Purpose  : Trigger/control inputs, BRAM read port and audio output of the
//            clip mixer. gain_shift exists only when AUDIO_CLIP_MIXER_GAIN_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface audio_clip_mixer_if #(
  parameter int NUM_CH        = 2,
  parameter int ADDRESS_WIDTH = 15
);
  logic [NUM_CH-1:0]                    trig;
  logic [NUM_CH-1:0]                    stop;
  logic [NUM_CH-1:0]                    loop_mode;
  logic [NUM_CH-1:0][ADDRESS_WIDTH-1:0] clip_start;
  logic [NUM_CH-1:0][ADDRESS_WIDTH-1:0] clip_len;
`ifdef AUDIO_CLIP_MIXER_GAIN_EN
  logic [NUM_CH-1:0][1:0]               gain_shift;
`endif
  logic [ADDRESS_WIDTH-1:0]             bram_addr;
  logic [7:0]                           bram_data_out;
  logic [7:0]                           audio_sample_out;
  logic                                 sample_tick;
  logic [NUM_CH-1:0]                    busy;

  // Game logic / ROM side.
  modport master (
`ifdef AUDIO_CLIP_MIXER_GAIN_EN
    output gain_shift,
`endif
    output trig, stop, loop_mode, clip_start, clip_len, bram_data_out,
    input  bram_addr, audio_sample_out, sample_tick, busy
  );

  // Mixer side.
  modport slave (
`ifdef AUDIO_CLIP_MIXER_GAIN_EN
    input  gain_shift,
`endif
    input  trig, stop, loop_mode, clip_start, clip_len, bram_data_out,
    output bram_addr, audio_sample_out, sample_tick, busy
  );
endinterface
`default_nettype wire

// File: rtl/audio_clip_mixer_divider.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_divider
// Purpose  : Free-running 0..LIMIT counter with a 1-cycle terminal-count pulse.
// Revision : 1.0 - initial release
// ============================================================================
module audio_sample_divider #(
  parameter int LIMIT = 99
) (
  input  logic clk,
  input  logic rst_n,
  output logic tc
);
  localparam int            CW       = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] TERMINAL = CW'(LIMIT);

  logic [CW-1:0] r_count;

  // Count up and wrap at the terminal value; never paused by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_count == TERMINAL) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tc = (r_count == TERMINAL);
endmodule
`default_nettype wire

// File: rtl/audio_clip_mixer.sv
`default_nettype none
// ============================================================================
// Module   : audio_clip_mixer
// Purpose  : Plays NUM_CH clips from a shared 1-cycle-latency BRAM, mixes them
//            with saturation and emits one offset-binary sample per frame.
//            Define AUDIO_CLIP_MIXER_GAIN_EN for per-channel right-shift gain.
// Revision : 1.0 - initial release
// ============================================================================
module audio_clip_mixer
  import audio_clip_mixer_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int SAMPLE_RATE_HZ = 16_000,
  parameter int CLK_DIV_LIMIT  = (CLK_FREQ_HZ / SAMPLE_RATE_HZ) - 1,
  parameter int ADDRESS_WIDTH  = 15,
  parameter int NUM_CH         = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  audio_clip_mixer_if.slave bus
);
  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int              ACC_W   = 8 + $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t                               r_state, w_state_next;
  logic [CH_W-1:0]                      r_ch;
  logic                                 w_frame_tc, w_apply;
  logic [NUM_CH-1:0]                    w_trig_ok;
  logic [NUM_CH-1:0][1:0]               w_gain_in;
  logic [ADDRESS_WIDTH-1:0]             w_bram_addr;

  logic [NUM_CH-1:0]                    r_pend_trig, r_pend_stop, r_pend_loop;
  logic [NUM_CH-1:0][ADDRESS_WIDTH-1:0] r_pend_base, r_pend_len;
  logic [NUM_CH-1:0][1:0]               r_pend_gain;

  logic [NUM_CH-1:0]                    r_active, r_loop, r_done;
  logic [NUM_CH-1:0][ADDRESS_WIDTH-1:0] r_base, r_len, r_off;
  logic [NUM_CH-1:0][1:0]               r_gain;

  logic signed [ACC_W-1:0]              r_acc;
  logic signed [7:0]                    w_ch_sample, w_ch_scaled, w_ch_contrib;
  logic [7:0]                           r_sample;
  logic                                 r_tick;

`ifdef AUDIO_CLIP_MIXER_GAIN_EN
  assign w_gain_in = bus.gain_shift;
`else
  assign w_gain_in = '0;
`endif

  audio_sample_divider #(
    .LIMIT (CLK_DIV_LIMIT)
  ) u_divider (
    .clk   (CLK),
    .rst_n (RESET_N),
    .tc    (w_frame_tc)
  );

  // Frame start happens on the edge that leaves IDLE; pending requests land there.
  assign w_apply = (r_state == ST_IDLE) && w_frame_tc;

  // A trigger with a zero-length clip is dropped before it can become pending.
  always_comb begin
    w_trig_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_trig_ok[i] = bus.trig[i] && (bus.clip_len[i] != '0);
    end
  end

  // Frame sequencer next state; the BRAM address is only driven in ISSUE.
  always_comb begin
    w_state_next = r_state;
    w_bram_addr  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_frame_tc) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_bram_addr  = r_base[r_ch] + r_off[r_ch];
        w_state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_state_next = (r_ch == LAST_CH) ? ST_OUTPUT : ST_ISSUE;
      end
      ST_OUTPUT: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Frame sequencer state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Channel slot pointer: restarts at ch0 each frame, steps after each CAPTURE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ch <= '0;
    end else if (w_apply) begin
      r_ch <= '0;
    end else if ((r_state == ST_CAPTURE) && (r_ch != LAST_CH)) begin
      r_ch <= r_ch + CH_W'(1);
    end
  end

  // Hold trig/stop pulses and clip parameters until the next frame start;
  // a pulse arriving on the apply cycle itself waits for the following frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pend_trig <= '0;
      r_pend_stop <= '0;
      r_pend_loop <= '0;
      r_pend_base <= '0;
      r_pend_len  <= '0;
      r_pend_gain <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_pend_trig[i] <= (r_pend_trig[i] && !w_apply) || w_trig_ok[i];
        r_pend_stop[i] <= (r_pend_stop[i] && !w_apply) || bus.stop[i];
        if (w_trig_ok[i]) begin
          r_pend_loop[i] <= bus.loop_mode[i];
          r_pend_base[i] <= bus.clip_start[i];
          r_pend_len[i]  <= bus.clip_len[i];
          r_pend_gain[i] <= w_gain_in[i];
        end
      end
    end
  end

  // Per-channel playback state: requests applied at frame start (stop beats
  // trig, finished one-shots retire here), offsets advance in CAPTURE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_active <= '0;
      r_loop   <= '0;
      r_done   <= '0;
      r_base   <= '0;
      r_len    <= '0;
      r_off    <= '0;
      r_gain   <= '0;
    end else if (w_apply) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_done[i] <= 1'b0;
        if (r_pend_stop[i]) begin
          r_active[i] <= 1'b0;
        end else if (r_pend_trig[i]) begin
          r_active[i] <= 1'b1;
          r_loop[i]   <= r_pend_loop[i];
          r_base[i]   <= r_pend_base[i];
          r_len[i]    <= r_pend_len[i];
          r_gain[i]   <= r_pend_gain[i];
          r_off[i]    <= '0;
        end else if (r_done[i]) begin
          r_active[i] <= 1'b0;
        end
      end
    end else if ((r_state == ST_CAPTURE) && r_active[r_ch]) begin
      if (r_off[r_ch] == (r_len[r_ch] - ADDRESS_WIDTH'(1))) begin
        r_off[r_ch] <= '0;
        if (!r_loop[r_ch]) begin
          r_done[r_ch] <= 1'b1;
        end
      end else begin
        r_off[r_ch] <= r_off[r_ch] + ADDRESS_WIDTH'(1);
      end
    end
  end

  assign w_ch_sample  = to_signed_sample(bus.bram_data_out);
  assign w_ch_scaled  = w_ch_sample >>> r_gain[r_ch];
  assign w_ch_contrib = r_active[r_ch] ? w_ch_scaled : 8'sd0;

  // Mix accumulation per slot, then saturate and publish once per frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_acc    <= '0;
      r_sample <= SILENCE;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= (r_state == ST_OUTPUT);
      if (w_apply) begin
        r_acc <= '0;
      end else if (r_state == ST_CAPTURE) begin
        r_acc <= r_acc + ACC_W'(w_ch_contrib);
      end
      if (r_state == ST_OUTPUT) begin
        r_sample <= to_offset_binary(saturate(32'(r_acc)));
      end
    end
  end

  assign bus.bram_addr        = w_bram_addr;
  assign bus.audio_sample_out = r_sample;
  assign bus.sample_tick      = r_tick;
  assign bus.busy             = r_active;
endmodule
`default_nettype wire

// File: tb/tb_audio_clip_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_clip_mixer
// Purpose  : Directed self-checking bench for audio_clip_mixer (NUM_CH=2,
//            100-cycle frames) with a sample scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_clip_mixer;
  localparam int NUM_CH     = 2;
  localparam int AW         = 15;
  localparam int LIMIT      = 99;
  localparam int FRAME      = LIMIT + 1;
  localparam int TICK_PHASE = 2 * NUM_CH + 1;

  typedef struct {
    string      tag;
    logic [7:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic force_en;
  logic [7:0] force_val;
  int cyc;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  audio_clip_mixer_if #(.NUM_CH(NUM_CH), .ADDRESS_WIDTH(AW)) bus ();

  audio_clip_mixer #(
    .CLK_FREQ_HZ    (1_600_000),
    .SAMPLE_RATE_HZ (16_000),
    .CLK_DIV_LIMIT  (LIMIT),
    .ADDRESS_WIDTH  (AW),
    .NUM_CH         (NUM_CH)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  // BRAM model: data = low address byte, or a forced constant.
  always @(posedge clk) begin
    bus.bram_data_out <= force_en ? force_val : bus.bram_addr[7:0];
  end

  // Cycles since reset release; frame start is where cyc % FRAME == 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard: every tick must land at the right phase and match the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && bus.sample_tick === 1'b1) begin
      checks++;
      assert ((cyc % FRAME) == TICK_PHASE) else begin
        failures++;
        $error("FAIL tick_phase observed=%0d expected=%0d", cyc % FRAME, TICK_PHASE);
      end
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_tick observed=%0h expected=none", bus.audio_sample_out);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (bus.audio_sample_out === e.value) else begin
          failures++;
          $error("FAIL %s observed=%0h expected=%0h", e.tag, bus.audio_sample_out, e.value);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_sample(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag   = tag;
    e.value = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge clk);
      seen = (bus.sample_tick === 1'b1);
    end
    checks++;
    assert (seen) else begin
      failures++;
      $error("FAIL tick_timeout observed=0 expected=1");
    end
  endtask

  task automatic goto_phase(input int ph);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((cyc % FRAME) != ph) && (n < 2 * FRAME));
  endtask

  task automatic set_clip(input int c, input logic [AW-1:0] start,
                          input logic [AW-1:0] len, input logic lp);
    bus.clip_start[c] = start;
    bus.clip_len[c]   = len;
    bus.loop_mode[c]  = lp;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] t, input logic [NUM_CH-1:0] s);
    @(negedge clk);
    bus.trig = t;
    bus.stop = s;
    @(negedge clk);
    bus.trig = '0;
    bus.stop = '0;
  endtask

  initial begin
    rst_n          = 1'b0;
    force_en       = 1'b0;
    force_val      = 8'h00;
    bus.trig       = '0;
    bus.stop       = '0;
    bus.loop_mode  = '0;
    bus.clip_start = '0;
    bus.clip_len   = '0;
    repeat (3) @(negedge clk);
    check("rst_bram_addr", bus.bram_addr, 0);
    check("rst_sample", bus.audio_sample_out, 8'h80);
    check("rst_tick", bus.sample_tick, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    // Idle: silence every frame.
    for (int k = 0; k < 2; k++) begin
      goto_phase(0);
      check("idle_busy", bus.busy, 0);
      expect_sample("idle", 8'h80);
      wait_tick();
    end

    // One-shot ch0, 4 samples from 0x100.
    set_clip(0, 15'h100, 15'd4, 1'b0);
    pulse(2'b01, 2'b00);
    for (int k = 0; k < 5; k++) begin
      goto_phase(0);
      check("oneshot_busy", bus.busy, (k < 4) ? 1 : 0);
      if (k < 4) check("oneshot_addr", bus.bram_addr, 32'h100 + k);
      expect_sample("oneshot", (k < 4) ? 8'(k) : 8'h80);
      wait_tick();
    end

    // Looped ch0, length 3, then stop.
    set_clip(0, 15'h100, 15'd3, 1'b1);
    pulse(2'b01, 2'b00);
    for (int k = 0; k < 7; k++) begin
      goto_phase(0);
      check("loop_addr", bus.bram_addr, 32'h100 + (k % 3));
      expect_sample("loop", 8'(k % 3));
      wait_tick();
    end
    pulse(2'b00, 2'b01);
    goto_phase(0);
    check("stop_busy", bus.busy, 0);
    expect_sample("stop_silence", 8'h80);
    wait_tick();

    // Two looped channels mixed: +32+64 = 96, +33+65 = 98.
    set_clip(0, 15'h1A0, 15'd2, 1'b1);
    set_clip(1, 15'h2C0, 15'd2, 1'b1);
    pulse(2'b11, 2'b00);
    for (int k = 0; k < 2; k++) begin
      goto_phase(0);
      check("mix_busy", bus.busy, 3);
      expect_sample("mix", 8'hE0 + 8'(2 * k));
      goto_phase(2);
      check("mix_addr_ch1", bus.bram_addr, 32'h2C0 + k);
      wait_tick();
    end

    // Saturation and its edges with both channels reading the same byte.
    force_en  = 1'b1;
    force_val = 8'hF0;
    goto_phase(0); expect_sample("sat_pos", 8'hFF); wait_tick();
    force_val = 8'h10;
    goto_phase(0); expect_sample("sat_neg", 8'h00); wait_tick();
    force_val = 8'hC0;
    goto_phase(0); expect_sample("sat_edge_pos", 8'hFF); wait_tick();
    force_val = 8'hBF;
    goto_phase(0); expect_sample("below_max", 8'hFE); wait_tick();
    force_val = 8'h40;
    goto_phase(0); expect_sample("exact_min", 8'h00); wait_tick();
    force_en = 1'b0;
    pulse(2'b00, 2'b11);
    goto_phase(0);
    check("stop_both_busy", bus.busy, 0);
    expect_sample("stop_both", 8'h80);
    wait_tick();

    // Trig+stop on ch1 together (stop wins) while ch0 starts a one-shot.
    set_clip(0, 15'h100, 15'd8, 1'b0);
    set_clip(1, 15'h2C0, 15'd2, 1'b1);
    pulse(2'b11, 2'b10);
    goto_phase(0);
    check("trigstop_busy", bus.busy, 1);
    expect_sample("trigstop_s0", 8'h00);
    wait_tick();
    goto_phase(0); expect_sample("trigstop_s1", 8'h01); wait_tick();

    // Retrigger ch0 mid-clip: restarts at offset 0.
    pulse(2'b01, 2'b00);
    goto_phase(0);
    check("restart_addr0", bus.bram_addr, 32'h100);
    expect_sample("restart_s0", 8'h00);
    wait_tick();
    goto_phase(0);
    check("restart_addr1", bus.bram_addr, 32'h101);
    expect_sample("restart_s1", 8'h01);
    wait_tick();

    // Zero-length trig on ch1 is ignored.
    set_clip(1, 15'h2C0, 15'd0, 1'b1);
    pulse(2'b10, 2'b00);
    goto_phase(0);
    check("len0_busy", bus.busy, 1);
    expect_sample("len0_s2", 8'h02);
    wait_tick();

    // Reset in the middle of a frame with both channels active.
    set_clip(0, 15'h1A0, 15'd2, 1'b1);
    set_clip(1, 15'h2C0, 15'd2, 1'b1);
    pulse(2'b11, 2'b00);
    goto_phase(0);
    check("pre_reset_busy", bus.busy, 3);
    expect_sample("pre_reset", 8'hE0);
    wait_tick();
    goto_phase(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_sample", bus.audio_sample_out, 8'h80);
    check("mid_rst_tick", bus.sample_tick, 0);
    check("mid_rst_addr", bus.bram_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto_phase(0);
    check("post_rst_busy", bus.busy, 0);
    expect_sample("post_reset", 8'h80);
    wait_tick();

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/audio_clip_mixer.md
# audio_clip_mixer

Multi-channel sound-effect player: plays up to NUM_CH independent clips from one shared single-port audio BRAM, each clip triggered by game logic as one-shot or looped. Sums all active channels in signed arithmetic with saturation and emits one 8-bit offset-binary sample per sample period. Sits between the sound-effect ROM (BRAM, 1-cycle read latency) and the PWM/DAC audio output stage.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency
- SAMPLE_RATE_HZ, 16_000, output sample rate
- CLK_DIV_LIMIT, (CLK_FREQ_HZ/SAMPLE_RATE_HZ)-1, divider terminal count; must be >= 2*NUM_CH+2
- ADDRESS_WIDTH, 15, BRAM address width
- NUM_CH, 2, number of playback channels (1..8)
- CLK  in  1  system clock
- RESET_N  in  1  reset; asynchronous, active-low
- trig  in  NUM_CH  per-channel start pulse (1 cycle)
- stop  in  NUM_CH  per-channel stop pulse (1 cycle)
- loop_mode  in  NUM_CH  1 = wrap at clip end, 0 = one-shot; sampled with trig
- clip_start  in  NUM_CH x ADDRESS_WIDTH  clip base address; sampled with trig
- clip_len  in  NUM_CH x ADDRESS_WIDTH  clip length in samples; sampled with trig
- bram_addr  out  ADDRESS_WIDTH  BRAM read address
- bram_data_out  in  8  BRAM read data, valid 1 cycle after bram_addr
- audio_sample_out  out  8  mixed sample, offset-binary (0x80 = silence)
- sample_tick  out  1  1-cycle pulse: new audio_sample_out valid
- busy  out  NUM_CH  channel i playing

## Operation
- Per channel: active flag, loop flag, base, length, offset counter (ADDRESS_WIDTH bits).
- trig/stop captured into pending registers any cycle; applied at the next frame start. Stop and trig pending together: stop wins. Trig on a playing channel restarts it at offset 0. Trig with clip_len==0 ignored.
- Frame FSM (states IDLE, ISSUE, CAPTURE, OUTPUT): IDLE waits for divider terminal count -> apply pending -> ISSUE ch0. ISSUE drives bram_addr = base+offset (modulo 2^ADDRESS_WIDTH) -> CAPTURE. CAPTURE registers data, converts to signed (data-128), adds to accumulator if active (inactive adds 0), advances offset; -> ISSUE next ch, or OUTPUT after last ch. OUTPUT saturates, writes output -> IDLE.
- Every channel consumes its 2-cycle slot whether active or not (fixed latency).
- Offset advance: offset==len-1 -> loop: offset 0; one-shot: clear active after this sample is mixed. Else offset+1.
- Accumulator width 8+clog2(NUM_CH) signed; saturate to [-128,+127]; output = result+128.
- All channels inactive -> output 0x80, sample_tick still pulses every frame.

## Timing
- Reset values: bram_addr 0, audio_sample_out 0x80, sample_tick 0, busy 0, FSM IDLE, divider 0, pending cleared.
- Frame period exactly CLK_DIV_LIMIT+1 cycles; divider free-running, unaffected by FSM.
- Frame start = cycle after divider terminal count; audio_sample_out updates and sample_tick high 2*NUM_CH+1 cycles after frame start, same cycle.
- busy reflects applied state: rises at frame start after trig, falls the frame start after last one-shot sample.
- Reset mid-frame: all state to reset values immediately; no partial output.

## Configuration
- AUDIO_CLIP_MIXER_GAIN_EN defined: extra input gain_shift (NUM_CH x 2 bits), sampled with trig; signed channel sample arithmetically right-shifted by gain_shift before accumulation.
- Undefined: port absent, unity gain.

## Structure
- audio_pkg: FSM state enum, SILENCE=8'h80, SAMPLE_MIN/SAMPLE_MAX signed limits, saturation function.
- Sub-module audio_sample_divider: parametrised divider producing 1-cycle terminal-count pulse.

## Test plan
- NUM_CH=2, CLK_DIV_LIMIT=99, no trig -> sample_tick every 100 cycles, output 0x80, bram slots still issued.
- trig ch0 start=0x100 len=4 one-shot, BRAM data=addr[7:0] -> outputs 0x00,0x01,0x02,0x03 then 0x80; busy[0] falls after 4th frame.
- ch0 loop len=3 -> addresses 0x100,0x101,0x102,0x100,... indefinitely; stop -> 0x80 next frame.
- Both channels data 0xF0 (+112 each) -> output 0xFF (saturated); both 0x10 (-112 each) -> 0x00.
- trig and stop ch1 same cycle -> ch1 stays idle; trig ch0 while playing -> restarts at offset 0 next frame.
- RESET_N low mid-frame with both active -> all outputs at reset values, busy 0, next frame outputs 0x80.
